// File: rtl/ahb_err_slv_pkg.sv
// Shared constants and state encoding for the AHB-Lite error slave.
package ahb_err_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_ERR1 = 2'b10,
        ST_ERR2 = 2'b11
    } state_t;

    // NONSEQ and SEQ both have htrans[1] set; IDLE/BUSY do not.
    function automatic logic is_active(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage

// File: rtl/ahb_err_slv_if.sv
// AHB-Lite slave-side bus bundle used by the error slave.
interface ahb_err_slv_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              hsel;
    logic [1:0]        htrans;
    logic [ADDR_W-1:0] haddr;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [3:0]        hprot;
    logic              hmastlock;
    logic [DATA_W-1:0] hwdata;
    logic              hreadyin;
    logic [DATA_W-1:0] hrdata;
    logic              hready;
    logic [1:0]        hresp;

    modport master (
        output hsel, htrans, haddr, hwrite, hsize, hburst, hprot, hmastlock, hwdata, hreadyin,
        input  hrdata, hready, hresp
    );

    modport slave (
        input  hsel, htrans, haddr, hwrite, hsize, hburst, hprot, hmastlock, hwdata, hreadyin,
        output hrdata, hready, hresp
    );
endinterface

// File: rtl/ahb_err_slv_log.sv
// First-fault capture, saturating fault counter and optional irq (macro ERR_SLV_IRQ_EN).
module err_slv_log
    import ahb_err_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              pll_core_cpuclk,
    input  logic              pad_cpu_rst_b,
    input  logic              accept,
    input  logic [ADDR_W-1:0] haddr,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic              err_clr,
    output logic              err_vld,
    output logic [ADDR_W-1:0] err_addr,
    output logic [3:0]        err_info,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_irq
);

    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            err_vld  <= 1'b0;
            err_addr <= '0;
            err_info <= '0;
            err_cnt  <= '0;
        end else if (err_clr) begin
            // A fault arriving with the clear is the first entry of the fresh log.
            if (accept) begin
                err_vld  <= 1'b1;
                err_addr <= haddr;
                err_info <= {hwrite, hsize};
                err_cnt  <= CNT_W'(1);
            end else begin
                err_vld  <= 1'b0;
                err_addr <= '0;
                err_info <= '0;
                err_cnt  <= '0;
            end
        end else if (accept) begin
            if (!err_vld) begin
                err_vld  <= 1'b1;
                err_addr <= haddr;
                err_info <= {hwrite, hsize};
            end
            if (err_cnt != '1) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

`ifdef ERR_SLV_IRQ_EN
    logic irq_q;

    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= err_vld;
        end
    end

    assign err_irq = irq_q;
`else
    assign err_irq = 1'b0;
`endif

endmodule

// File: rtl/ahb_err_slv.sv
// AHB-Lite default/error slave: WAIT_CYCLES wait states then a two-cycle ERROR response.
// Optional level interrupt from the fault log is enabled by defining ERR_SLV_IRQ_EN.
//
// state | meaning
// IDLE  | no transfer pending, hready=1 / OKAY
// WAIT  | wait states, hready=0 / OKAY, wait_cnt counts down
// ERR1  | first ERROR cycle, hready=0
// ERR2  | second ERROR cycle, hready=1; may accept the next transfer
module ahb_err_slv
    import ahb_err_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 0,
    parameter int CNT_W       = 8
) (
    input  logic              pll_core_cpuclk,
    input  logic              pad_cpu_rst_b,
    ahb_err_slv_if.slave      bus,
    input  logic              err_clr,
    output logic              err_vld,
    output logic [ADDR_W-1:0] err_addr,
    output logic [3:0]        err_info,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_irq
);

    // WAIT_CYCLES is limited to 0..15 so the load value fits the 4-bit down-counter.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam bit         HAS_WAIT  = (WAIT_CYCLES > 0);

    state_t     state;
    logic [3:0] wait_cnt;
    logic       hready_q;
    logic [1:0] hresp_q;
    logic       accept;

    assign accept = bus.hsel & is_active(bus.htrans) & bus.hreadyin;

    always_ff @(posedge pll_core_cpuclk or negedge pad_cpu_rst_b) begin
        if (!pad_cpu_rst_b) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            hready_q <= 1'b1;
            hresp_q  <= HRESP_OKAY;
        end else begin
            case (state)
                ST_IDLE, ST_ERR2: begin
                    if (accept) begin
                        hready_q <= 1'b0;
                        if (HAS_WAIT) begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                            hresp_q  <= HRESP_OKAY;
                        end else begin
                            state   <= ST_ERR1;
                            hresp_q <= HRESP_ERROR;
                        end
                    end else begin
                        state    <= ST_IDLE;
                        hready_q <= 1'b1;
                        hresp_q  <= HRESP_OKAY;
                    end
                end
                ST_WAIT: begin
                    hready_q <= 1'b0;
                    if (wait_cnt == 4'd0) begin
                        state   <= ST_ERR1;
                        hresp_q <= HRESP_ERROR;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                        hresp_q  <= HRESP_OKAY;
                    end
                end
                ST_ERR1: begin
                    state    <= ST_ERR2;
                    hready_q <= 1'b1;
                    hresp_q  <= HRESP_ERROR;
                end
                default: begin
                    state    <= ST_IDLE;
                    hready_q <= 1'b1;
                    hresp_q  <= HRESP_OKAY;
                end
            endcase
        end
    end

    assign bus.hready = hready_q;
    assign bus.hresp  = hresp_q;
    assign bus.hrdata = '0;

    logic unused_bus;
    assign unused_bus = ^{bus.hburst, bus.hprot, bus.hmastlock, bus.hwdata};

    err_slv_log #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W)
    ) u_log (
        .pll_core_cpuclk (pll_core_cpuclk),
        .pad_cpu_rst_b   (pad_cpu_rst_b),
        .accept          (accept),
        .haddr           (bus.haddr),
        .hwrite          (bus.hwrite),
        .hsize           (bus.hsize),
        .err_clr         (err_clr),
        .err_vld         (err_vld),
        .err_addr        (err_addr),
        .err_info        (err_info),
        .err_cnt         (err_cnt),
        .err_irq         (err_irq)
    );

endmodule

// File: tb/tb_ahb_err_slv.sv
// Directed bench for ahb_err_slv: three instances (0 waits, 3 waits, 2-bit counter).
module tb_ahb_err_slv;
    import ahb_err_pkg::*;

`ifdef ERR_SLV_IRQ_EN
    localparam logic IRQ = 1'b1;
`else
    localparam logic IRQ = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    ahb_err_slv_if #(.ADDR_W(32), .DATA_W(32)) b0 ();
    ahb_err_slv_if #(.ADDR_W(32), .DATA_W(32)) b3 ();
    ahb_err_slv_if #(.ADDR_W(32), .DATA_W(32)) bc ();

    // Each slave is the only one on its bus, so bus-level hready is its own hreadyout.
    assign b0.hreadyin = b0.hready;
    assign b3.hreadyin = b3.hready;
    assign bc.hreadyin = bc.hready;

    logic        clr0, clr3, clrc;
    logic        vld0, vld3, vldc;
    logic [31:0] addr0, addr3, addrc;
    logic [3:0]  info0, info3, infoc;
    logic [7:0]  cnt0, cnt3;
    logic [1:0]  cntc;
    logic        irq0, irq3, irqc;

    ahb_err_slv #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0), .CNT_W(8)) dut0 (
        .pll_core_cpuclk(clk), .pad_cpu_rst_b(rst_b), .bus(b0.slave), .err_clr(clr0),
        .err_vld(vld0), .err_addr(addr0), .err_info(info0), .err_cnt(cnt0), .err_irq(irq0));

    ahb_err_slv #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(3), .CNT_W(8)) dut3 (
        .pll_core_cpuclk(clk), .pad_cpu_rst_b(rst_b), .bus(b3.slave), .err_clr(clr3),
        .err_vld(vld3), .err_addr(addr3), .err_info(info3), .err_cnt(cnt3), .err_irq(irq3));

    ahb_err_slv #(.ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0), .CNT_W(2)) dutc (
        .pll_core_cpuclk(clk), .pad_cpu_rst_b(rst_b), .bus(bc.slave), .err_clr(clrc),
        .err_vld(vldc), .err_addr(addrc), .err_info(infoc), .err_cnt(cntc), .err_irq(irqc));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        {b0.hsel, b0.htrans, b0.haddr, b0.hwrite, b0.hsize} = '0;
        {b0.hburst, b0.hprot, b0.hmastlock, b0.hwdata} = '0;
        {b3.hsel, b3.htrans, b3.haddr, b3.hwrite, b3.hsize} = '0;
        {b3.hburst, b3.hprot, b3.hmastlock, b3.hwdata} = '0;
        {bc.hsel, bc.htrans, bc.haddr, bc.hwrite, bc.hsize} = '0;
        {bc.hburst, bc.hprot, bc.hmastlock, bc.hwdata} = '0;
        {clr0, clr3, clrc} = '0;

        #12;
        chk("rst_hready", b0.hready, 1'b1);
        chk("rst_hresp", b0.hresp, 2'b00);
        chk("rst_hrdata", b0.hrdata, 32'h0);
        chk("rst_vld", vld0, 1'b0);
        chk("rst_addr", addr0, 32'h0);
        chk("rst_info", info0, 4'h0);
        chk("rst_cnt", cnt0, 8'h0);
        chk("rst_irq", irq0, 1'b0);
        #10 rst_b = 1'b1;

        // 1: zero-wait read fault
        b0.hsel = 1'b1; b0.htrans = HTRANS_NONSEQ; b0.haddr = 32'h4000_0000;
        b0.hwrite = 1'b0; b0.hsize = 3'd2;
        tick();
        b0.htrans = HTRANS_IDLE;
        chk("t1_err1_hready", b0.hready, 1'b0);
        chk("t1_err1_hresp", b0.hresp, 2'b01);
        chk("t1_addr", addr0, 32'h4000_0000);
        chk("t1_cnt", cnt0, 8'd1);
        chk("t1_vld", vld0, 1'b1);
        chk("t1_irq_early", irq0, 1'b0);
        tick();
        chk("t1_err2_hready", b0.hready, 1'b1);
        chk("t1_err2_hresp", b0.hresp, 2'b01);
        chk("t1_irq", irq0, IRQ);
        tick();
        chk("t1_idle_hresp", b0.hresp, 2'b00);

        // 3: IDLE / BUSY / unselected SEQ give zero-wait OKAY
        b0.htrans = HTRANS_IDLE; tick();
        chk("t3_idle_hready", b0.hready, 1'b1);
        chk("t3_idle_hresp", b0.hresp, 2'b00);
        b0.htrans = HTRANS_BUSY; tick();
        chk("t3_busy_hready", b0.hready, 1'b1);
        chk("t3_busy_hresp", b0.hresp, 2'b00);
        b0.hsel = 1'b0; b0.htrans = HTRANS_SEQ; tick();
        chk("t3_nosel_hready", b0.hready, 1'b1);
        chk("t3_nosel_hresp", b0.hresp, 2'b00);
        chk("t3_cnt", cnt0, 8'd1);
        b0.hsel = 1'b1; b0.htrans = HTRANS_IDLE;

        // 4: clear, then back-to-back faults
        clr0 = 1'b1; tick(); clr0 = 1'b0;
        chk("t4_clr_vld", vld0, 1'b0);
        chk("t4_clr_cnt", cnt0, 8'd0);
        chk("t4_clr_irq", irq0, IRQ);
        b0.htrans = HTRANS_NONSEQ; b0.haddr = 32'h4000_0010;
        tick();
        chk("t4_a_hready", b0.hready, 1'b0);
        chk("t4_a_hresp", b0.hresp, 2'b01);
        chk("t4_irq_low", irq0, 1'b0);
        b0.haddr = 32'h4000_0020;
        tick();
        chk("t4_a2_hready", b0.hready, 1'b1);
        chk("t4_a2_hresp", b0.hresp, 2'b01);
        tick();
        b0.htrans = HTRANS_IDLE;
        chk("t4_b_hready", b0.hready, 1'b0);
        chk("t4_b_hresp", b0.hresp, 2'b01);
        chk("t4_cnt", cnt0, 8'd2);
        chk("t4_addr", addr0, 32'h4000_0010);
        tick();
        chk("t4_b2_hresp", b0.hresp, 2'b01);
        tick();
        chk("t4_end_hready", b0.hready, 1'b1);
        chk("t4_end_hresp", b0.hresp, 2'b00);

        // 2: three wait states before the ERROR pair
        b3.hsel = 1'b1; b3.htrans = HTRANS_NONSEQ; b3.haddr = 32'h5000_0004;
        b3.hwrite = 1'b1; b3.hsize = 3'd2;
        tick();
        b3.htrans = HTRANS_IDLE;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t2_wait%0d_hready", i), b3.hready, 1'b0);
            chk($sformatf("t2_wait%0d_hresp", i), b3.hresp, 2'b00);
            tick();
        end
        chk("t2_err1_hready", b3.hready, 1'b0);
        chk("t2_err1_hresp", b3.hresp, 2'b01);
        tick();
        chk("t2_err2_hready", b3.hready, 1'b1);
        chk("t2_err2_hresp", b3.hresp, 2'b01);
        tick();
        chk("t2_idle_hresp", b3.hresp, 2'b00);
        chk("t2_info", info3, 4'b1010);
        chk("t2_addr", addr3, 32'h5000_0004);
        chk("t2_cnt", cnt3, 8'd1);

        // 5: counter saturation, then clear concurrent with a new fault
        bc.hsel = 1'b1; bc.hwrite = 1'b0; bc.hsize = 3'd0;
        for (int i = 0; i < 5; i++) begin
            bc.htrans = HTRANS_NONSEQ; bc.haddr = 32'h6000_0000 + 32'(i * 4);
            tick();
            bc.htrans = HTRANS_IDLE;
            tick();
            tick();
        end
        chk("t5_sat_cnt", cntc, 2'd3);
        chk("t5_sat_addr", addrc, 32'h6000_0000);
        clrc = 1'b1; bc.htrans = HTRANS_NONSEQ; bc.haddr = 32'h6000_0040;
        bc.hwrite = 1'b1; bc.hsize = 3'd1;
        tick();
        clrc = 1'b0; bc.htrans = HTRANS_IDLE;
        chk("t5_clr_cnt", cntc, 2'd1);
        chk("t5_clr_vld", vldc, 1'b1);
        chk("t5_clr_addr", addrc, 32'h6000_0040);
        chk("t5_clr_info", infoc, 4'b1001);
        chk("t5_clr_irq", irqc, IRQ);
        tick();
        tick();

        // 6: asynchronous reset during ERR1
        b0.htrans = HTRANS_NONSEQ; b0.haddr = 32'h4000_0030;
        tick();
        b0.htrans = HTRANS_IDLE;
        chk("t6_err1_hready", b0.hready, 1'b0);
        #2 rst_b = 1'b0;
        #1;
        chk("t6_rst_hready", b0.hready, 1'b1);
        chk("t6_rst_hresp", b0.hresp, 2'b00);
        chk("t6_rst_cnt", cnt0, 8'd0);
        chk("t6_rst_vld", vld0, 1'b0);
        chk("t6_rst_irq", irq0, 1'b0);
        #4 rst_b = 1'b1;
        tick();
        chk("t6_post_hready", b0.hready, 1'b1);
        chk("t6_post_hresp", b0.hresp, 2'b00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
